core_sequencer: RTL

Parametrised multi-cycle control and PC unit for the RV32I core, replacing the fixed six-state one-hot sequence with a handshake-driven FSM. Instruction and data memories may take any number of cycles (req/ack). Non-memory instructions skip the memory stage. Misaligned fetch and illegal instructions trap. Sits between instruction memory, decoder, register file, ALU and data memory; owns `pc`, the instruction register and the retired-instruction counter.

---
 rtl/core_pkg.sv | 22 ++
 rtl/core_sequencer_pc_next.sv | 35 +++
 rtl/core_sequencer.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/core_pkg.sv
// Shared types and constants for the RV32I multi-cycle control path.
package core_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXECUTE,
    S_MEM,
    S_WB,
    S_TRAP
  } seq_state_t;

  typedef enum logic [1:0] {
    CAUSE_NONE       = 2'd0,
    CAUSE_MISALIGNED = 2'd1,
    CAUSE_ILLEGAL    = 2'd2
  } trap_cause_t;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;

endpackage

// File: rtl/core_sequencer_pc_next.sv
// Next-PC selection: jalr target, pc-relative jump/branch target, or sequential pc+4.
module pc_next #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] rs1_data,
  input  logic            jal,
  input  logic            jalr,
  input  logic            branch,
  input  logic            branch_taken,
  output logic [XLEN-1:0] next_pc,
  output logic [XLEN-1:0] pc_plus4
);

  logic signed [XLEN-1:0] imm_s;
  logic        [XLEN-1:0] jalr_sum;
  logic        [XLEN-1:0] rel_target;

  assign imm_s      = imm;
  assign pc_plus4   = pc + XLEN'(4);
  assign rel_target = pc + imm_s;
  assign jalr_sum   = rs1_data + imm_s;

  // jalr clears bit 0 of the target; bit 1 is kept so misalignment can trap later
  always_comb begin
    next_pc = pc_plus4;
    if (jalr) begin
      next_pc = {jalr_sum[XLEN-1:1], 1'b0};
    end else if (jal || (branch && branch_taken)) begin
      next_pc = rel_target;
    end
  end

endmodule

// File: rtl/core_sequencer.sv
// Handshake-driven multi-cycle sequencer: owns pc, instruction register, retire counter and trap state.
module core_sequencer
  import core_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  output logic             imem_req,
  output logic [XLEN-1:0]  imem_addr,
  input  logic             imem_ack,
  input  logic [31:0]      imem_rdata,
  output logic [31:0]      inst,
  input  logic             dc_illegal,
  input  logic             dc_branch,
  input  logic             dc_jal,
  input  logic             dc_jalr,
  input  logic             dc_load,
  input  logic             dc_store,
  input  logic [XLEN-1:0]  dc_imm,
  input  logic [XLEN-1:0]  rs1_data,
  input  logic             branch_taken,
  output logic             dmem_req,
  output logic             dmem_we,
  input  logic             dmem_ack,
  input  logic [XLEN-1:0]  dmem_rdata,
  output logic [XLEN-1:0]  ld_data,
  output logic             rf_we,
  output logic [XLEN-1:0]  pc,
  output logic [XLEN-1:0]  pc_plus4,
  output logic [CNT_W-1:0] retired,
  output logic             trap,
  output logic [1:0]       trap_cause
);

  seq_state_t       state_q, state_d;
  trap_cause_t      cause_q, trap_code;
  logic [XLEN-1:0]  pc_q;
  logic [XLEN-1:0]  next_pc;
  logic [31:0]      inst_q;
  logic [XLEN-1:0]  ld_data_q;
  logic [CNT_W-1:0] retired_q;
  logic             store_q;
  logic             wb_we_q;

  pc_next #(.XLEN(XLEN)) u_pc_next (
    .pc           (pc_q),
    .imm          (dc_imm),
    .rs1_data     (rs1_data),
    .jal          (dc_jal),
    .jalr         (dc_jalr),
    .branch       (dc_branch),
    .branch_taken (branch_taken),
    .next_pc      (next_pc),
    .pc_plus4     (pc_plus4)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // A misaligned pc is caught on the way into FETCH, so no fetch request is ever issued for it
  always_comb begin
    state_d   = state_q;
    trap_code = CAUSE_NONE;
    case (state_q)
      S_IDLE: begin
        if (run) begin
          if (pc_q[1:0] != 2'b00) begin
            state_d   = S_TRAP;
            trap_code = CAUSE_MISALIGNED;
          end else begin
            state_d = S_FETCH;
          end
        end
      end
      S_FETCH:   if (imem_ack) state_d = S_DECODE;
      S_DECODE: begin
        if (dc_illegal) begin
          state_d   = S_TRAP;
          trap_code = CAUSE_ILLEGAL;
        end else begin
          state_d = S_EXECUTE;
        end
      end
      S_EXECUTE: state_d = (dc_load || dc_store) ? S_MEM : S_WB;
      S_MEM:     if (dmem_ack) state_d = S_WB;
      S_WB: begin
        if (!run) begin
          state_d = S_IDLE;
        end else if (next_pc[1:0] != 2'b00) begin
          state_d   = S_TRAP;
          trap_code = CAUSE_MISALIGNED;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_TRAP:    state_d = S_TRAP;
      default:   state_d = S_IDLE;
    endcase
  end

  // Store/writeback qualifiers are latched in EXECUTE so MEM/WB strobes come from flops
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q      <= RESET_PC;
      inst_q    <= NOP_INST;
      ld_data_q <= '0;
      retired_q <= '0;
      cause_q   <= CAUSE_NONE;
      store_q   <= 1'b0;
      wb_we_q   <= 1'b0;
    end else begin
      if (state_q == S_FETCH && imem_ack) begin
        inst_q <= imem_rdata;
      end
      if (state_q == S_EXECUTE) begin
        store_q <= dc_store;
        wb_we_q <= !(dc_branch || dc_store);
      end
      if (state_q == S_MEM && dmem_ack && dc_load) begin
        ld_data_q <= dmem_rdata;
      end
      if (state_q == S_WB) begin
        pc_q      <= next_pc;
        retired_q <= retired_q + CNT_W'(1);
      end
      if (state_q != S_TRAP && state_d == S_TRAP) begin
        cause_q <= trap_code;
      end
    end
  end

  assign imem_req   = (state_q == S_FETCH);
  assign imem_addr  = pc_q;
  assign dmem_req   = (state_q == S_MEM);
  assign dmem_we    = (state_q == S_MEM) && store_q;
  assign rf_we      = (state_q == S_WB) && wb_we_q;
  assign inst       = inst_q;
  assign ld_data    = ld_data_q;
  assign pc         = pc_q;
  assign retired    = retired_q;
  assign trap       = (state_q == S_TRAP);
  assign trap_cause = cause_q;

endmodule
